// File: rtl/axi_wr_burst_master.sv
// AXI4 write master: splits one write command into INCR bursts at 4KB and MAX_BURST limits.
// Optional macro AXI_WR_ERR_ABORT_EN: an error response drains the command's remaining data.
module axi_wr_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_BURST  = 256
) (
    input  logic                    clk,
    input  logic                    ARESTN,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [15:0]             cmd_beats,
    input  logic [2:0]              cmd_size,
    input  logic                    wr_data_valid,
    output logic                    wr_data_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [7:0]              AWLEN,
    output logic [2:0]              AWSIZE,
    output logic [1:0]              AWBURST,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WLAST,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic                    done,
    output logic [1:0]              done_resp,
    output logic                    busy
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, CALC, AW, W, B, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic                  out_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           remaining;
    logic [2:0]            size;
    logic [7:0]            beat_cnt;
    logic [1:0]            resp;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;

    logic                  illegal;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic [ADDR_WIDTH-1:0] step;
    logic [12:0]           room;
    logic [12:0]           room_beats;
    logic [16:0]           blen;
    logic                  beat_fire;
    logic                  last_beat;
    int                    lane_off;

    // EXOKAY carries no error, so it ranks with OKAY; DECERR outranks SLVERR.
    function automatic logic [1:0] resp_merge(input logic [1:0] acc, input logic [1:0] r);
        logic [1:0] sev;
        sev = r[1] ? r : 2'b00;
        return (sev > acc) ? sev : acc;
    endfunction

    assign align_mask = ADDR_WIDTH'((32'd1 << size) - 32'd1);
    assign step       = ADDR_WIDTH'(32'd1 << size);
    assign illegal    = (size > 3'(LANE_W)) || (remaining == 16'd0) || ((addr & align_mask) != '0);
    assign room       = 13'h1000 - {1'b0, addr[11:0]};
    assign room_beats = room >> size;
    assign beat_fire  = (state == W) && wr_data_valid && WREADY;
    assign last_beat  = (beat_cnt == aw_len);
    assign lane_off   = int'(addr[LANE_W-1:0]);

    always_comb begin
        blen = {1'b0, remaining};
        if (blen > 17'(MAX_BURST)) blen = 17'(MAX_BURST);
        if (blen > {4'b0, room_beats}) blen = {4'b0, room_beats};
    end

    always_ff @(posedge clk) begin
        if (!ARESTN) begin
            state  <= IDLE;
            out_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            out_en <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        cmd_ready     = 1'b0;
        AWVALID       = 1'b0;
        WVALID        = 1'b0;
        wr_data_ready = 1'b0;
        BREADY        = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = out_en;
                if (cmd_valid && out_en) state_nxt = CALC;
            end
            CALC: state_nxt = illegal ? DONE : AW;
            AW: begin
                AWVALID = 1'b1;
                if (AWREADY) state_nxt = W;
            end
            W: begin
                WVALID        = wr_data_valid;
                wr_data_ready = WREADY;
                if (beat_fire && last_beat) state_nxt = B;
            end
            B: begin
                BREADY = 1'b1;
                if (BVALID) begin
`ifdef AXI_WR_ERR_ABORT_EN
                    if (BRESP[1] && remaining != 16'd0) state_nxt = DRAIN;
                    else if (remaining == 16'd0)        state_nxt = DONE;
                    else                                state_nxt = CALC;
`else
                    state_nxt = (remaining == 16'd0) ? DONE : CALC;
`endif
                end
            end
            // Swallow the aborted command's leftover beats so the data stream stays aligned.
            DRAIN: begin
                wr_data_ready = 1'b1;
                if (wr_data_valid && remaining == 16'd1) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!ARESTN) begin
            addr      <= '0;
            remaining <= '0;
            size      <= '0;
            beat_cnt  <= '0;
            resp      <= '0;
            aw_addr   <= '0;
            aw_len    <= '0;
            aw_size   <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid && out_en) begin
                    addr      <= cmd_addr;
                    remaining <= cmd_beats;
                    size      <= cmd_size;
                    resp      <= 2'b00;
                end
                CALC: if (illegal) begin
                    resp <= RESP_SLVERR;
                end else begin
                    aw_addr   <= addr;
                    aw_len    <= 8'(blen - 17'd1);
                    aw_size   <= size;
                    remaining <= remaining - 16'(blen);
                    beat_cnt  <= '0;
                end
                W: if (beat_fire) begin
                    addr     <= addr + step;
                    beat_cnt <= beat_cnt + 8'd1;
                end
                B: if (BVALID) resp <= resp_merge(resp, BRESP);
                DRAIN: if (wr_data_valid) remaining <= remaining - 16'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        WSTRB = '0;
        if (state == W) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (i >= lane_off && i < lane_off + (1 << size)) WSTRB[i] = 1'b1;
            end
        end
    end

    assign WLAST     = (state == W) && last_beat;
    assign WDATA     = wr_data;
    assign AWADDR    = aw_addr;
    assign AWLEN     = aw_len;
    assign AWSIZE    = aw_size;
    assign AWBURST   = 2'b01;
    assign done_resp = resp;
    assign busy      = (state != IDLE);

endmodule
